msg_assembler: RTL and testbench

Parametrised AXI-Stream message assembler. It accepts a multi-beat stream on the `s_*` interface and compacts the kept bytes of each beat (sparse `s_tkeep` allowed) into a message buffer of up to MAX_MSG_BYTES. When `s_tlast` arrives it presents the whole message with its byte length and error status on a valid/ready output port. It sits between the ingress stream and downstream message parsers, and adds real backpressure, multi-beat accumulation, length reporting and overflow handling.

---
 rtl/msg_assembler.sv | 134 +++++++++++++
 tb/tb_msg_assembler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_assembler.sv
// AXI-Stream message assembler: compacts kept bytes of each beat into a message
// buffer and presents the whole message with length and error status on tlast.
module msg_assembler #(
    parameter int unsigned MAX_MSG_BYTES = 32,
    parameter int unsigned DATA_BYTES    = 8,
    parameter int unsigned LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [8*DATA_BYTES-1:0]    s_tdata,
    input  logic [DATA_BYTES-1:0]      s_tkeep,
    input  logic                       s_tlast,
    input  logic                       s_tuser,
    output logic [8*MAX_MSG_BYTES-1:0] msg_data,
    output logic [LEN_W-1:0]           msg_len,
    output logic                       msg_valid,
    input  logic                       msg_ready,
    output logic                       msg_error,
    output logic                       msg_overflow
);

    localparam int unsigned IDX_W = (MAX_MSG_BYTES > 1) ? $clog2(MAX_MSG_BYTES) : 1;
    localparam int unsigned POS_W = $clog2(MAX_MSG_BYTES + DATA_BYTES + 1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       buf_q [MAX_MSG_BYTES];
    logic [7:0]       buf_n [MAX_MSG_BYTES];
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_n;
    logic [POS_W-1:0] pos;
    logic             over;
    logic             err_q;
    logic             ovf_q;
    logic             valid_q;

    // Pack kept lanes in ascending order from the current fill level; bytes past capacity are dropped.
    always_comb begin
        buf_n = buf_q;
        pos   = POS_W'(cnt_q);
        for (int i = 0; i < int'(DATA_BYTES); i++) begin
            if (s_tkeep[i]) begin
                if (pos < POS_W'(MAX_MSG_BYTES)) begin
                    buf_n[pos[IDX_W-1:0]] = s_tdata[8*i +: 8];
                end
                pos = pos + POS_W'(1);
            end
        end
        over  = (pos > POS_W'(MAX_MSG_BYTES));
        cnt_n = over ? LEN_W'(MAX_MSG_BYTES) : LEN_W'(pos);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < int'(MAX_MSG_BYTES); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (s_tvalid) begin
                        buf_q <= buf_n;
                        cnt_q <= cnt_n;
                        if (s_tuser || over) begin
                            err_q <= 1'b1;
                        end
                        if (over) begin
                            ovf_q <= 1'b1;
                        end
                        if (s_tlast) begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                        end else if (over) begin
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (s_tvalid) begin
                        if (s_tuser) begin
                            err_q <= 1'b1;
                        end
                        if (s_tlast) begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (msg_ready) begin
                        state   <= ACCUM;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        for (int i = 0; i < int'(MAX_MSG_BYTES); i++) begin
                            buf_q[i] <= '0;
                        end
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    // Unfilled bytes are kept at zero, so the buffer is presented directly.
    always_comb begin
        msg_data = '0;
        for (int i = 0; i < int'(MAX_MSG_BYTES); i++) begin
            msg_data[8*i +: 8] = buf_q[i];
        end
    end

    assign s_tready     = !rst && (state != HOLD);
    assign msg_len      = cnt_q;
    assign msg_valid    = valid_q;
    assign msg_error    = err_q;
    assign msg_overflow = ovf_q;

endmodule

// File: tb/tb_msg_assembler.sv
// Scoreboard bench for msg_assembler: a byte-level model queues expected messages,
// a monitor pops and compares them on each output handshake.
module tb_msg_assembler;

    localparam int unsigned MAXB  = 32;
    localparam int unsigned DB    = 8;
    localparam int unsigned LEN_W = $clog2(MAXB + 1);

    typedef struct {
        logic [8*MAXB-1:0] data;
        int                len;
        logic              err;
        logic              ovf;
    } msg_t;

    logic              clk;
    logic              rst;
    logic              s_tvalid;
    logic              s_tready;
    logic [8*DB-1:0]   s_tdata;
    logic [DB-1:0]     s_tkeep;
    logic              s_tlast;
    logic              s_tuser;
    logic [8*MAXB-1:0] msg_data;
    logic [LEN_W-1:0]  msg_len;
    logic              msg_valid;
    logic              msg_ready;
    logic              msg_error;
    logic              msg_overflow;

    int tests_run    = 0;
    int tests_failed = 0;
    int last_stalls  = 0;

    msg_t              sb[$];
    logic [8*MAXB-1:0] m_data;
    int                m_raw;
    logic              m_err;

    msg_assembler #(.MAX_MSG_BYTES(MAXB), .DATA_BYTES(DB), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .msg_data(msg_data), .msg_len(msg_len), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .msg_error(msg_error), .msg_overflow(msg_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8*MAXB-1:0] got, input logic [8*MAXB-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data = '0;
        m_raw  = 0;
        m_err  = 1'b0;
    endtask

    // Reference behaviour: store while below capacity, count every kept byte.
    task automatic model_beat(input logic [8*DB-1:0] d, input logic [DB-1:0] k, input logic l, input logic u);
        msg_t m;
        for (int i = 0; i < int'(DB); i++) begin
            if (k[i]) begin
                if (m_raw < int'(MAXB)) m_data[8*m_raw +: 8] = d[8*i +: 8];
                m_raw++;
            end
        end
        m_err = m_err | u;
        if (l) begin
            m.data = m_data;
            m.len  = (m_raw > int'(MAXB)) ? int'(MAXB) : m_raw;
            m.ovf  = (m_raw > int'(MAXB));
            m.err  = m_err | m.ovf;
            sb.push_back(m);
            model_reset();
        end
    endtask

    function automatic logic [8*DB-1:0] ramp(input int base);
        logic [8*DB-1:0] r;
        for (int i = 0; i < int'(DB); i++) r[8*i +: 8] = 8'(base + i);
        return r;
    endfunction

    task automatic send_beat(input logic [8*DB-1:0] d, input logic [DB-1:0] k, input logic l, input logic u);
        int n = 0;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        while (!s_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        last_stalls = n;
        if (n >= 20) begin
            check("tready_timeout", 1, 0);
            s_tvalid = 1'b0;
            return;
        end
        model_beat(d, k, l, u);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = 8'($urandom);
        s_tlast  = 1'($urandom);
        s_tuser  = 1'($urandom);
        if (l) check("valid_latency", msg_valid, 1);
    endtask

    // Output monitor: every handshake must match the oldest expected message.
    always @(negedge clk) begin
        if (!rst && msg_valid && msg_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_msg", 1, 0);
            end else begin
                msg_t e;
                e = sb.pop_front();
                check("msg_len", msg_len, e.len);
                check("msg_data", msg_data, e.data);
                check("msg_error", msg_error, e.err);
                check("msg_overflow", msg_overflow, e.ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8*MAXB-1:0] hold_data;
        logic [LEN_W-1:0]  hold_len;
        int                n;

        clk = 1'b0; rst = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
        msg_ready = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tready", s_tready, 0);
        check("rst_valid", msg_valid, 0);
        check("rst_len", msg_len, 0);
        check("rst_data", msg_data, 0);
        check("rst_error", msg_error, 0);
        check("rst_overflow", msg_overflow, 0);
        rst = 1'b0;
        #1;
        check("post_rst_tready", s_tready, 1);

        // Four full beats, ramp 0x00..0x1F
        for (int b = 0; b < 4; b++) send_beat(ramp(8*b), 8'hFF, b == 3, 1'b0);
        check("full_len_direct", msg_len, 32);

        // Sparse keep
        send_beat(64'h0706050403020100, 8'hA5, 1'b1, 1'b0);
        check("sparse_low_word", msg_data[31:0], 32'h07050200);
        check("sparse_upper_zero", msg_data[8*MAXB-1:32], 0);

        // Overflow with five full beats
        for (int b = 0; b < 5; b++) begin
            send_beat(ramp(8*b), 8'hFF, b == 4, 1'b0);
            if (b == 4) check("ovf_tready_beat5", last_stalls, 0);
        end
        check("ovf_flag_direct", msg_overflow, 1);

        // Overflow partially filling the last four slots
        for (int b = 0; b < 3; b++) send_beat(ramp(8*b), 8'hFF, 1'b0, 1'b0);
        send_beat(ramp(24), 8'h0F, 1'b0, 1'b0);
        send_beat(ramp(100), 8'hFF, 1'b1, 1'b0);

        // tuser on beat two only
        for (int b = 0; b < 3; b++) send_beat(ramp(40 + 8*b), 8'hFF, b == 2, b == 1);
        check("tuser_ovf_direct", msg_overflow, 0);

        // Zero-length message
        send_beat(ramp(200), 8'h00, 1'b0, 1'b0);
        send_beat(ramp(208), 8'h00, 1'b1, 1'b0);
        check("zero_len_direct", msg_len, 0);

        // Backpressure on the output port
        send_beat(ramp(60), 8'hFF, 1'b0, 1'b0);
        msg_ready = 1'b0;
        send_beat(ramp(68), 8'h3C, 1'b1, 1'b0);
        hold_data = msg_data;
        hold_len  = msg_len;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", msg_valid, 1);
            check("bp_tready", s_tready, 0);
            check("bp_len_stable", msg_len, hold_len);
            check("bp_data_stable", msg_data, hold_data);
        end
        @(posedge clk);
        #1;
        msg_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_after", msg_valid, 0);
        check("bp_tready_after", s_tready, 1);

        // Reset in the middle of a message
        for (int b = 0; b < 2; b++) send_beat(ramp(80 + 8*b), 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tready", s_tready, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb.delete();
        send_beat(64'h00000000AABBCCDD, 8'h0F, 1'b1, 1'b0);
        check("midrst_low_word", msg_data[31:0], 32'hAABBCCDD);
        check("midrst_upper_zero", msg_data[8*MAXB-1:32], 0);
        check("midrst_error", msg_error, 0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
